game_turn_ctrl: RTL and testbench

Parametrised turn-sequencing FSM for N-player grid games (tic-tac-toe generalised to ROWS x COLS boards).
- Owns the board state and validates moves internally: in range and cell empty.
- Rotates turns among PLAYERS and enforces an optional per-turn timeout.
- Declares the end of game from an external line checker's verdict or a full board.
- Sits between the input/debounce logic and the VGA renderer, which consumes the flat colour bus.

---
 rtl/game_pkg.sv | 42 ++++
 rtl/board_regfile.sv | 50 +++++
 rtl/game_turn_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_game_turn_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the grid-game turn controller:
// FSM state encoding, line-checker outcome codes and the cell colour table.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT     = 3'd1,
        ST_VALIDATE = 3'd2,
        ST_COMMIT   = 3'd3,
        ST_CHECK    = 3'd4,
        ST_ADVANCE  = 3'd5,
        ST_END      = 3'd6,
        ST_ERROR    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        OC_NONE = 2'd0,
        OC_WIN  = 2'd1,
        OC_TIE  = 2'd2,
        OC_RSVD = 2'd3
    } outcome_t;

    localparam logic [2:0] DEFAULT_COLOR = 3'b111;
    localparam logic [2:0] P1_COLOR      = 3'b010;
    localparam logic [2:0] P2_COLOR      = 3'b101;
    localparam logic [2:0] P3_COLOR      = 3'b100;
    localparam logic [2:0] P4_COLOR      = 3'b001;

    // Owner code to display colour; anything outside 1..4 renders as empty.
    function automatic logic [2:0] player_color(input logic [2:0] p);
        logic [2:0] c;
        case (p)
            3'd1:    c = P1_COLOR;
            3'd2:    c = P2_COLOR;
            3'd3:    c = P3_COLOR;
            3'd4:    c = P4_COLOR;
            default: c = DEFAULT_COLOR;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/board_regfile.sv
// Board owner storage: one owner code per cell, synchronous clear,
// a single write port, one random read port and the flat read bus.
module board_regfile #(
    parameter int NCELL = 9,
    parameter int IDX_W = 4,
    parameter int PL_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   we,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [PL_W-1:0]        wr_data,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [PL_W-1:0]        rd_data,
    output logic [NCELL*PL_W-1:0]  owner_flat
);

    logic [PL_W-1:0] cells [NCELL];

    // Clear (reset or controller request) wins over the write port.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            for (int i = 0; i < NCELL; i++) begin
                cells[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < NCELL; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    cells[i] <= wr_data;
                end
            end
        end
    end

    // Read port; indices past the last cell read as empty.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NCELL; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = cells[i];
            end
        end
    end

    for (genvar g = 0; g < NCELL; g++) begin : g_flat
        assign owner_flat[g*PL_W +: PL_W] = cells[g];
    end

endmodule

// File: rtl/game_turn_ctrl.sv
// Turn sequencer for ROWS x COLS grid games with PLAYERS players.
// Validates and commits moves, rotates turns, applies an optional per-turn
// timeout and declares the end of game from the line checker or a full board.
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | board held clear, waiting for start
// WAIT     | waiting for the current player's check (timeout runs)
// VALIDATE | registered move checked for range and empty cell
// COMMIT   | owner written, move counter bumped
// CHECK    | line-checker verdict / full-board test
// ADVANCE  | hand the turn to the next player
// END      | game over, board frozen, waits for start to re-arm
// ERROR    | unreachable encoding, recovers to IDLE
module game_turn_ctrl
    import game_pkg::*;
#(
    parameter int ROWS        = 3,
    parameter int COLS        = 3,
    parameter int PLAYERS     = 2,
    parameter int COLOR_W     = 3,
    parameter int TIMEOUT_CYC = 0,
    parameter int IDX_W       = $clog2(ROWS*COLS),
    parameter int PL_W        = $clog2(PLAYERS+1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          check,
    input  logic [IDX_W-1:0]              move,
    input  logic [1:0]                    outcome,
    output logic [ROWS*COLS*PL_W-1:0]     board_owner,
    output logic [ROWS*COLS*COLOR_W-1:0]  board_color,
    output logic [PL_W-1:0]               user,
    output logic                          invalid,
    output logic                          timeout,
    output logic                          done,
    output logic [PL_W-1:0]               winner
);

    localparam int NCELL = ROWS * COLS;
    localparam logic [IDX_W:0] NCELL_C = (IDX_W+1)'(NCELL);
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = (TIMEOUT_CYC > 0) ? TO_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [PL_W-1:0] FIRST_PL = PL_W'(1);
    localparam logic [PL_W-1:0] LAST_PL  = PL_W'(PLAYERS);

    state_t             state;
    logic [IDX_W-1:0]   move_q;
    logic [IDX_W:0]     move_cnt;
    logic [TO_W-1:0]    to_cnt;
    logic               start_low;
    logic               rf_we;
    logic               rf_clr;
    logic [PL_W-1:0]    cell_owner;
    logic               move_oob;
    logic               timer_exp;

    assign rf_we     = (state == ST_COMMIT);
    assign rf_clr    = (state == ST_IDLE);
    assign move_oob  = ({1'b0, move_q} >= NCELL_C);
    assign timer_exp = (TIMEOUT_CYC > 0) && (to_cnt == '0);

    board_regfile #(
        .NCELL (NCELL),
        .IDX_W (IDX_W),
        .PL_W  (PL_W)
    ) u_board (
        .clk        (clk),
        .rst        (rst),
        .clr        (rf_clr),
        .we         (rf_we),
        .wr_idx     (move_q),
        .wr_data    (user),
        .rd_idx     (move_q),
        .rd_data    (cell_owner),
        .owner_flat (board_owner)
    );

    // Turn-timeout down-counter: reloaded outside WAIT, so every entry to
    // WAIT (new turn or rejected move) starts a full interval.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt <= TO_LOAD;
        end else if (state != ST_WAIT) begin
            to_cnt <= TO_LOAD;
        end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - TO_W'(1);
        end
    end

    // Main sequencing FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            user      <= '0;
            winner    <= '0;
            done      <= 1'b0;
            invalid   <= 1'b0;
            timeout   <= 1'b0;
            move_q    <= '0;
            move_cnt  <= '0;
            start_low <= 1'b0;
        end else begin
            invalid <= 1'b0;
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    move_cnt  <= '0;
                    winner    <= '0;
                    done      <= 1'b0;
                    start_low <= 1'b0;
                    user      <= '0;
                    if (start) begin
                        user  <= FIRST_PL;
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (check) begin
                        move_q <= move;
                        state  <= ST_VALIDATE;
                    end else if (timer_exp) begin
                        timeout <= 1'b1;
                        state   <= ST_ADVANCE;
                    end
                end
                ST_VALIDATE: begin
                    if (move_oob || (cell_owner != '0)) begin
                        invalid <= 1'b1;
                        state   <= ST_WAIT;
                    end else begin
                        state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    move_cnt <= move_cnt + (IDX_W+1)'(1);
                    state    <= ST_CHECK;
                end
                ST_CHECK: begin
                    // Reserved verdict code falls through as "in progress".
                    if (outcome == OC_WIN) begin
                        winner <= user;
                        done   <= 1'b1;
                        state  <= ST_END;
                    end else if ((outcome == OC_TIE) || (move_cnt == NCELL_C)) begin
                        winner <= '0;
                        done   <= 1'b1;
                        state  <= ST_END;
                    end else begin
                        state <= ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    user  <= (user == LAST_PL) ? FIRST_PL : user + FIRST_PL;
                    state <= ST_WAIT;
                end
                ST_END: begin
                    done <= 1'b1;
                    // A held start must drop and rise again to re-arm.
                    if (!start) begin
                        start_low <= 1'b1;
                    end else if (start_low) begin
                        done   <= 1'b0;
                        winner <= '0;
                        user   <= '0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    user   <= '0;
                    winner <= '0;
                    done   <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-cell colour lookup for the renderer.
    for (genvar g = 0; g < NCELL; g++) begin : g_color
        logic [PL_W-1:0] own;
        assign own = board_owner[g*PL_W +: PL_W];
        assign board_color[g*COLOR_W +: COLOR_W] =
            COLOR_W'((own == '0) ? DEFAULT_COLOR : player_color(3'(own)));
    end

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Bench for game_turn_ctrl: three instances (3x3/2 players, 3x3/2 players
// with a 16-cycle timeout, 4x4/3 players). Expected observations are queued
// with a due cycle when stimulus is driven and compared when that cycle comes.
module tb_game_turn_ctrl;

    localparam int K_OWN  = 0;
    localparam int K_COL  = 1;
    localparam int K_USER = 2;
    localparam int K_INV  = 3;
    localparam int K_DONE = 4;
    localparam int K_WIN  = 5;
    localparam int K_BRDZ = 6;
    localparam int K_TO   = 7;

    typedef struct {
        int    due;
        int    dut;
        int    kind;
        int    idx;
        int    val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int cyc   = 0;
    int n_vec = 0;
    int n_err = 0;

    logic clk;
    logic rst;
    logic rst_c;

    logic        start_a, check_a, inv_a, to_a, done_a;
    logic [3:0]  move_a;
    logic [1:0]  outcome_a, user_a, winner_a;
    logic [17:0] owner_a;
    logic [26:0] color_a;

    logic        start_b, check_b, inv_b, to_b, done_b;
    logic [3:0]  move_b;
    logic [1:0]  outcome_b, user_b, winner_b;
    logic [17:0] owner_b;
    logic [26:0] color_b;

    logic        start_c, check_c, inv_c, to_c, done_c;
    logic [3:0]  move_c;
    logic [1:0]  outcome_c, user_c, winner_c;
    logic [31:0] owner_c;
    logic [47:0] color_c;

    game_turn_ctrl #(.ROWS(3), .COLS(3), .PLAYERS(2), .COLOR_W(3), .TIMEOUT_CYC(0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .check(check_a), .move(move_a),
        .outcome(outcome_a), .board_owner(owner_a), .board_color(color_a),
        .user(user_a), .invalid(inv_a), .timeout(to_a), .done(done_a), .winner(winner_a)
    );

    game_turn_ctrl #(.ROWS(3), .COLS(3), .PLAYERS(2), .COLOR_W(3), .TIMEOUT_CYC(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .check(check_b), .move(move_b),
        .outcome(outcome_b), .board_owner(owner_b), .board_color(color_b),
        .user(user_b), .invalid(inv_b), .timeout(to_b), .done(done_b), .winner(winner_b)
    );

    game_turn_ctrl #(.ROWS(4), .COLS(4), .PLAYERS(3), .COLOR_W(3), .TIMEOUT_CYC(0)) dut_c (
        .clk(clk), .rst(rst_c), .start(start_c), .check(check_c), .move(move_c),
        .outcome(outcome_c), .board_owner(owner_c), .board_color(color_c),
        .user(user_c), .invalid(inv_c), .timeout(to_c), .done(done_c), .winner(winner_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int want);
        n_vec++;
        if (obs != want) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic int pcol(input int p);
        case (p)
            1:       return 2;
            2:       return 5;
            3:       return 4;
            4:       return 1;
            default: return 7;
        endcase
    endfunction

    function automatic int observe(input int d, input int k, input int idx);
        int r;
        r = -1;
        case (d)
            0: case (k)
                K_OWN:  r = 32'(owner_a[idx*2 +: 2]);
                K_COL:  r = 32'(color_a[idx*3 +: 3]);
                K_USER: r = 32'(user_a);
                K_INV:  r = 32'(inv_a);
                K_DONE: r = 32'(done_a);
                K_WIN:  r = 32'(winner_a);
                K_BRDZ: r = 32'(owner_a == '0);
                K_TO:   r = 32'(to_a);
                default: r = -1;
            endcase
            1: case (k)
                K_OWN:  r = 32'(owner_b[idx*2 +: 2]);
                K_COL:  r = 32'(color_b[idx*3 +: 3]);
                K_USER: r = 32'(user_b);
                K_INV:  r = 32'(inv_b);
                K_DONE: r = 32'(done_b);
                K_WIN:  r = 32'(winner_b);
                K_BRDZ: r = 32'(owner_b == '0);
                K_TO:   r = 32'(to_b);
                default: r = -1;
            endcase
            default: case (k)
                K_OWN:  r = 32'(owner_c[idx*2 +: 2]);
                K_COL:  r = 32'(color_c[idx*3 +: 3]);
                K_USER: r = 32'(user_c);
                K_INV:  r = 32'(inv_c);
                K_DONE: r = 32'(done_c);
                K_WIN:  r = 32'(winner_c);
                K_BRDZ: r = 32'(owner_c == '0);
                K_TO:   r = 32'(to_c);
                default: r = -1;
            endcase
        endcase
        return r;
    endfunction

    // Compare every expectation whose cycle has come, away from the active edge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                chk(sb[i].tag, observe(sb[i].dut, sb[i].kind, sb[i].idx), sb[i].val);
                sb.delete(i);
            end
        end
    end

    // Expect value after the (lat+1)-th rising edge from now; lat counts from
    // the edge that samples the stimulus driven at this negedge.
    task automatic exp_at(input int d, input int lat, input int k, input int idx,
                          input int val, input string tag);
        exp_t e;
        e.due  = cyc + 1 + lat;
        e.dut  = d;
        e.kind = k;
        e.idx  = idx;
        e.val  = val;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic set_check(input int d, input int mv, input int oc, input logic v);
        case (d)
            0: begin move_a = 4'(mv); outcome_a = 2'(oc); check_a = v; end
            1: begin move_b = 4'(mv); outcome_b = 2'(oc); check_b = v; end
            default: begin move_c = 4'(mv); outcome_c = 2'(oc); check_c = v; end
        endcase
    endtask

    // Accepted move: owner at +2, turn handed over (or game ended) at +4.
    task automatic play(input int d, input int mv, input int pl, input int nxt,
                        input int oc, input int fin, input string tag);
        set_check(d, mv, oc, 1'b1);
        exp_at(d, 1, K_OWN, mv, 0, {tag, "_own_early"});
        exp_at(d, 2, K_OWN, mv, pl, {tag, "_own"});
        if (d == 0) exp_at(d, 2, K_COL, mv, pcol(pl), {tag, "_col"});
        exp_at(d, 3, K_USER, 0, pl, {tag, "_user_hold"});
        exp_at(d, 4, K_USER, 0, nxt, {tag, "_user"});
        if (fin != 0) begin
            exp_at(d, 2, K_DONE, 0, 0, {tag, "_done_early"});
            exp_at(d, 3, K_DONE, 0, 1, {tag, "_done"});
            exp_at(d, 3, K_WIN, 0, (fin == 1) ? pl : 0, {tag, "_winner"});
        end else begin
            exp_at(d, 4, K_DONE, 0, 0, {tag, "_not_done"});
        end
        @(negedge clk);
        set_check(d, mv, oc, 1'b0);
        repeat (4) @(negedge clk);
    endtask

    // Rejected move: single invalid pulse at +1, turn kept, cell untouched.
    task automatic reject(input int d, input int mv, input int cur, input int own,
                          input string tag);
        set_check(d, mv, 0, 1'b1);
        exp_at(d, 0, K_INV, 0, 0, {tag, "_inv_early"});
        exp_at(d, 1, K_INV, 0, 1, {tag, "_inv"});
        exp_at(d, 2, K_INV, 0, 0, {tag, "_inv_drop"});
        exp_at(d, 2, K_USER, 0, cur, {tag, "_user"});
        if (own >= 0) exp_at(d, 2, K_OWN, mv, own, {tag, "_own"});
        @(negedge clk);
        set_check(d, mv, 0, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: cycle %0d reached without finishing", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; rst_c = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        set_check(0, 0, 0, 1'b0);
        set_check(1, 0, 0, 1'b0);
        set_check(2, 0, 0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset state
        exp_at(0, 0, K_USER, 0, 0, "rst_user");
        exp_at(0, 0, K_DONE, 0, 0, "rst_done");
        exp_at(0, 0, K_WIN,  0, 0, "rst_winner");
        exp_at(0, 0, K_INV,  0, 0, "rst_invalid");
        exp_at(0, 0, K_TO,   0, 0, "rst_timeout");
        exp_at(0, 0, K_BRDZ, 0, 1, "rst_board");
        exp_at(0, 0, K_COL,  4, 7, "rst_color");
        exp_at(2, 0, K_USER, 0, 0, "rst_c_user");
        @(negedge clk);
        rst = 1'b1; rst_c = 1'b1;

        // Game A: start, idle with timeout disabled
        start_a = 1'b1;
        exp_at(0, 0, K_USER, 0, 1, "a_start_user");
        @(negedge clk);
        for (int i = 0; i < 20; i += 5) exp_at(0, i, K_TO, 0, 0, "a_no_timeout");
        exp_at(0, 19, K_USER, 0, 1, "a_idle_user");
        repeat (20) @(negedge clk);

        play(0, 4, 1, 2, 0, 0, "a_p1_m4");
        exp_at(0, 0, K_COL, 5, 7, "a_empty_col");
        reject(0, 4, 2, 1, "a_p2_occupied");
        reject(0, 9, 2, -1, "a_p2_oob");
        play(0, 1, 2, 1, 0, 0, "a_p2_m1");
        exp_at(0, 0, K_COL, 1, 5, "a_p2_col");
        play(0, 0, 1, 2, 0, 0, "a_p1_m0");
        play(0, 2, 2, 1, 0, 0, "a_p2_m2");
        play(0, 8, 1, 1, 1, 1, "a_p1_m8_win");

        // Check pulse in END is ignored
        set_check(0, 5, 0, 1'b1);
        exp_at(0, 1, K_INV,  0, 0, "a_end_noinv");
        exp_at(0, 2, K_OWN,  5, 0, "a_end_own");
        exp_at(0, 4, K_DONE, 0, 1, "a_end_done");
        exp_at(0, 4, K_WIN,  0, 1, "a_end_winner");
        exp_at(0, 4, K_USER, 0, 1, "a_end_user");
        @(negedge clk);
        set_check(0, 5, 0, 1'b0);
        repeat (5) @(negedge clk);

        // Restart: start falls then rises
        start_a = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        exp_at(0, 0, K_DONE, 0, 0, "a_rs_done");
        exp_at(0, 0, K_USER, 0, 0, "a_rs_idle_user");
        exp_at(0, 0, K_BRDZ, 0, 0, "a_rs_board_kept");
        exp_at(0, 1, K_BRDZ, 0, 1, "a_rs_board_clear");
        exp_at(0, 1, K_USER, 0, 1, "a_rs_user");
        repeat (2) @(negedge clk);

        // Full board, reserved verdict on one move, tie on the ninth
        for (int i = 0; i < 9; i++) begin
            play(0, i, (i % 2) + 1, (i % 2 == 0) ? ((i == 8) ? 1 : 2) : 1,
                 (i == 2) ? 3 : 0, (i == 8) ? 2 : 0, $sformatf("a_fill%0d", i));
        end

        // Game B: timeout on P1, then P2 checks on the last allowed cycle
        start_b = 1'b1;
        exp_at(1, 15, K_TO,   0, 0, "b_to_early");
        exp_at(1, 16, K_TO,   0, 1, "b_to_pulse");
        exp_at(1, 16, K_USER, 0, 1, "b_to_user_hold");
        exp_at(1, 17, K_TO,   0, 0, "b_to_drop");
        exp_at(1, 17, K_USER, 0, 2, "b_to_user_next");
        exp_at(1, 17, K_BRDZ, 0, 1, "b_to_board");
        repeat (18) @(negedge clk);
        repeat (15) @(negedge clk);
        exp_at(1, 0, K_TO, 0, 0, "b_check_no_to");
        play(1, 3, 2, 1, 0, 0, "b_p2_late");

        // Game C: 3-player rotation, then reset during COMMIT
        start_c = 1'b1;
        exp_at(2, 0, K_USER, 0, 1, "c_start_user");
        @(negedge clk);
        play(2, 0, 1, 2, 0, 0, "c_m0");
        play(2, 1, 2, 3, 0, 0, "c_m1");
        play(2, 2, 3, 1, 0, 0, "c_m2");
        play(2, 3, 1, 2, 0, 0, "c_m3");
        set_check(2, 5, 0, 1'b1);
        @(negedge clk);
        set_check(2, 5, 0, 1'b0);
        @(negedge clk);
        rst_c = 1'b0;
        exp_at(2, 0, K_BRDZ, 0, 1, "c_rst_board");
        exp_at(2, 0, K_OWN,  5, 0, "c_rst_no_commit");
        exp_at(2, 0, K_USER, 0, 0, "c_rst_user");
        exp_at(2, 0, K_DONE, 0, 0, "c_rst_done");
        @(negedge clk);
        rst_c = 1'b1;
        start_c = 1'b0;
        exp_at(2, 2, K_USER, 0, 0, "c_idle_hold");
        exp_at(2, 2, K_BRDZ, 0, 1, "c_idle_board");
        repeat (3) @(negedge clk);
        start_c = 1'b1;
        exp_at(2, 0, K_USER, 0, 1, "c_restart_user");
        repeat (8) @(negedge clk);

        foreach (sb[i]) begin
            n_err++;
            $display("FAIL %s: expectation due at cycle %0d never compared (now %0d)",
                     sb[i].tag, sb[i].due, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
